// File: rtl/soc_system_pio_in_multi.sv
// Multi-channel input PIO on an Avalon-MM slave: per-channel synchroniser, edge capture
// with write-1-to-clear, per-bit irq mask and one registered level interrupt.

module soc_system_pio_in_lane #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_primed,
  input  logic             i_mask_we,
  input  logic             i_clr_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_s,
  output logic [WIDTH-1:0] o_cap,
  output logic [WIDTH-1:0] o_mask
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev, r_cap, r_mask;
  logic [WIDTH-1:0] w_edge, w_clr, w_set;

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_cap  = r_cap;
  assign o_mask = r_mask;

  generate
    if (EDGE_MODE == 0) begin : g_rise
      assign w_edge = o_s & ~r_prev;
    end else if (EDGE_MODE == 1) begin : g_fall
      assign w_edge = ~o_s & r_prev;
    end else begin : g_any
      assign w_edge = o_s ^ r_prev;
    end
  endgenerate

  // Sets are gated until the synchronisers have flushed their reset zeros.
  assign w_clr = i_clr_we ? i_wdata : '0;
  assign w_set = i_primed ? w_edge : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
      r_cap  <= '0;
      r_mask <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_prev <= o_s;
      r_cap  <= (r_cap & ~w_clr) | w_set;
      if (i_mask_we) r_mask <= i_wdata;
    end
  end
endmodule

module soc_system_pio_in_multi #(
  parameter  int NCH         = 4,
  parameter  int WIDTH       = 32,
  parameter  int SYNC_STAGES = 2,
  parameter  int EDGE_MODE   = 0,
  localparam int ADDR_W      = $clog2(NCH) + 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [NCH*WIDTH-1:0] in_port,
  output logic                 irq
);
  localparam int CH_W      = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

  logic [CH_W-1:0]             w_ch;
  logic [1:0]                  w_reg;
  logic                        w_ch_ok, w_wr, w_primed;
  logic [NCH-1:0][WIDTH-1:0]   w_s, w_cap, w_mask;
  logic [31:0]                 w_rd;
  logic [PRIME_W-1:0]          r_prime;
  logic [31:0]                 r_rd;
  logic                        r_irq;

  generate
    if (ADDR_W > 2) begin : g_ch
      assign w_ch = address[ADDR_W-1:2];
    end else begin : g_ch1
      assign w_ch = '0;
    end
  endgenerate

  assign w_reg    = address[1:0];
  assign w_ch_ok  = ({1'b0, w_ch} < (CH_W+1)'(NCH));
  assign w_wr     = chipselect & ~write_n & w_ch_ok;
  assign w_primed = (r_prime == PRIME_W'(PRIME_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prime <= '0;
    else if (!w_primed) r_prime <= r_prime + 1'b1;
  end

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_lane
      logic w_sel;
      assign w_sel = w_wr & (w_ch == CH_W'(c));
      soc_system_pio_in_lane #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(EDGE_MODE)
      ) u_lane (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_in      (in_port[c*WIDTH +: WIDTH]),
        .i_primed  (w_primed),
        .i_mask_we (w_sel & (w_reg == 2'd2)),
        .i_clr_we  (w_sel & (w_reg == 2'd3)),
        .i_wdata   (writedata[WIDTH-1:0]),
        .o_s       (w_s[c]),
        .o_cap     (w_cap[c]),
        .o_mask    (w_mask[c])
      );
    end
  endgenerate

  // Unmatched (out-of-range) channels fall through to zero.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_ch == CH_W'(i)) begin
        case (w_reg)
          2'd0:    w_rd[WIDTH-1:0] = w_s[i];
          2'd2:    w_rd[WIDTH-1:0] = w_mask[i];
          2'd3:    w_rd[WIDTH-1:0] = w_cap[i];
          default: w_rd = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd  <= '0;
      r_irq <= 1'b0;
    end else begin
      r_rd  <= w_rd;
      r_irq <= |(w_cap & w_mask);
    end
  end

  assign readdata = r_rd;
  assign irq      = r_irq;
endmodule
